// File: rtl/input_conditioner.sv
// Multi-channel raw-input conditioner: per-channel synchroniser chain, debounce
// counter, registered stable level and single-cycle rise/fall pulses.
module input_conditioner #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter bit               ADOPT_ON_RESET  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]  stable_q, stable_d;
    logic [WIDTH-1:0]  rise_q, rise_d;
    logic [WIDTH-1:0]  fall_q, fall_d;
    logic [CNT_W-1:0]  cnt_q [WIDTH];
    logic [CNT_W-1:0]  cnt_d [WIDTH];
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              init_done_q, init_done_d;

    logic [WIDTH-1:0]  sync_s;
    logic              adopt;
    logic              debounce_en;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Warm-up: in adopt mode, wait until the chain holds a real sample, then
    // take it as the stable level once. Without adopt mode debouncing is always on.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave it
        // unassigned and infer a latch.
        warm_d      = warm_q;
        init_done_d = init_done_q;
        adopt       = 1'b0;
        if (ADOPT_ON_RESET && !init_done_q) begin
            if (warm_q == WARM_LAST) begin
                init_done_d = 1'b1;
                adopt       = 1'b1;
            end else begin
                warm_d = warm_q + WARM_W'(1);
            end
        end
        debounce_en = !ADOPT_ON_RESET || init_done_q;
    end

    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end

        if (adopt) begin
            stable_d = sync_s;
        end else if (debounce_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_s[i];
                    rise_d[i]   = sync_s[i];
                    fall_d[i]   = ~sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q    <= RESET_VALUE;
            rise_q      <= '0;
            fall_q      <= '0;
            warm_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values; the synchroniser shift depends on this.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q    <= stable_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            warm_q      <= warm_d;
            init_done_q <= init_done_d;
        end
    end

    assign stable_out = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: two instances, one debouncing from
// reset (dut_a) and one adopting the first synchronised sample (dut_b).
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [3:0] raw_a, raw_b;
    logic [3:0] stable_a, rise_a, fall_a;
    logic [3:0] stable_b, rise_b, fall_b;

    int n_cmp = 0;
    int n_err = 0;

    always #50 clk = ~clk;

    input_conditioner #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3),
        .RESET_VALUE(4'b1000), .ADOPT_ON_RESET(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset_a), .raw_in(raw_a),
        .stable_out(stable_a), .rise_pulse(rise_a), .fall_pulse(fall_a)
    );

    input_conditioner #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3),
        .RESET_VALUE(4'b1000), .ADOPT_ON_RESET(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .raw_in(raw_b),
        .stable_out(stable_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] e_stable,
                           input logic [3:0] e_rise, input logic [3:0] e_fall);
        check({tag, ".stable"}, stable_a, e_stable);
        check({tag, ".rise"},   rise_a,   e_rise);
        check({tag, ".fall"},   fall_a,   e_fall);
    endtask

    task automatic check_b(input string tag, input logic [3:0] e_stable,
                           input logic [3:0] e_rise, input logic [3:0] e_fall);
        check({tag, ".stable"}, stable_b, e_stable);
        check({tag, ".rise"},   rise_b,   e_rise);
        check({tag, ".fall"},   fall_b,   e_fall);
    endtask

    // Advance one edge; outputs are sampled and inputs driven 10 units later.
    task automatic step();
        @(posedge clk);
        #10;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;
        raw_a   = 4'b0101;
        raw_b   = 4'b0110;

        // Reset asserted between edges takes effect at once and holds.
        #20;
        reset_a = 1'b1;
        reset_b = 1'b1;
        #1;
        check_a("rst_async", 4'b1000, 4'b0000, 4'b0000);
        check_b("rst_async_b", 4'b1000, 4'b0000, 4'b0000);
        for (int e = 1; e <= 3; e++) begin
            step();
            check_a($sformatf("rst_hold%0d", e), 4'b1000, 4'b0000, 4'b0000);
        end

        // Clean step on bit 0 (bit 3 held at its reset level).
        reset_a = 1'b0;
        raw_a   = 4'b1001;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_a($sformatf("clean_e%0d", e), 4'b1000, 4'b0000, 4'b0000);
        end
        step();
        check_a("clean_e5", 4'b1001, 4'b0001, 4'b0000);
        step();
        check_a("clean_e6", 4'b1001, 4'b0000, 4'b0000);

        // Two-cycle glitch on bit 1 is rejected.
        raw_a = 4'b1011;
        step();
        step();
        raw_a = 4'b1001;
        for (int e = 1; e <= 6; e++) begin
            step();
            check_a($sformatf("glitch_e%0d", e), 4'b1001, 4'b0000, 4'b0000);
        end

        // Three-cycle high on bit 1 is accepted, then its release is too.
        raw_a = 4'b1011;
        step();
        step();
        step();
        raw_a = 4'b1001;
        step();
        check_a("pulse3_e4", 4'b1001, 4'b0000, 4'b0000);
        step();
        check_a("pulse3_e5", 4'b1011, 4'b0010, 4'b0000);
        step();
        check_a("pulse3_e6", 4'b1011, 4'b0000, 4'b0000);
        step();
        check_a("pulse3_e7", 4'b1011, 4'b0000, 4'b0000);
        step();
        check_a("pulse3_e8", 4'b1001, 4'b0000, 4'b0010);
        step();
        check_a("pulse3_e9", 4'b1001, 4'b0000, 4'b0000);

        // Simultaneous rise on bit 2 and fall on bit 3.
        raw_a = 4'b0101;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_a($sformatf("simul_e%0d", e), 4'b1001, 4'b0000, 4'b0000);
        end
        step();
        check_a("simul_e5", 4'b0101, 4'b0100, 4'b1000);
        step();
        check_a("simul_e6", 4'b0101, 4'b0000, 4'b0000);

        // Reset one cycle before bit 1 would be accepted.
        raw_a = 4'b0111;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_a($sformatf("midrst_e%0d", e), 4'b0101, 4'b0000, 4'b0000);
        end
        reset_a = 1'b1;
        #1;
        check_a("midrst_async", 4'b1000, 4'b0000, 4'b0000);
        step();
        check_a("midrst_hold", 4'b1000, 4'b0000, 4'b0000);
        reset_a = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_a($sformatf("after_rst_e%0d", e), 4'b1000, 4'b0000, 4'b0000);
        end
        step();
        check_a("after_rst_e5", 4'b0111, 4'b0111, 4'b1000);
        step();
        check_a("after_rst_e6", 4'b0111, 4'b0000, 4'b0000);

        // Adopt mode: first valid sample loaded at edge 3 with no pulses.
        check_b("adopt_pre", 4'b1000, 4'b0000, 4'b0000);
        reset_b = 1'b0;
        step();
        check_b("adopt_e1", 4'b1000, 4'b0000, 4'b0000);
        step();
        check_b("adopt_e2", 4'b1000, 4'b0000, 4'b0000);
        step();
        check_b("adopt_e3", 4'b0110, 4'b0000, 4'b0000);
        step();
        check_b("adopt_e4", 4'b0110, 4'b0000, 4'b0000);

        // Later change on bit 0 debounces normally.
        raw_b = 4'b0111;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_b($sformatf("adopt_chg_e%0d", e), 4'b0110, 4'b0000, 4'b0000);
        end
        step();
        check_b("adopt_chg_e5", 4'b0111, 4'b0001, 4'b0000);
        step();
        check_b("adopt_chg_e6", 4'b0111, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
